// File: rtl/traffic_sequencer.sv
// traffic_sequencer: demand-driven NS/EW phase controller with pedestrian scramble; define TRAFFIC_FLASH_EN for flash mode
module traffic_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 3,
  parameter int WALK_T    = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash,
`endif
  output logic [5:0] lights,
  output logic       walk,
  output logic       tick,
  output logic [2:0] phase
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TLAST = CW'(TICK_DIV - 1);
  localparam logic [4:0] GMN = 5'(GREEN_MIN - 1);
  localparam logic [4:0] GMX = 5'(GREEN_MAX - 1);
  localparam logic [4:0] YEL = 5'(YELLOW_T - 1);
  localparam logic [4:0] ARD = 5'(ALLRED_T - 1);
  localparam logic [4:0] WLK = 5'(WALK_T - 1);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    NS_ALLRED = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    EW_ALLRED = 3'd5,
    PED_WALK  = 3'd6
`ifdef TRAFFIC_FLASH_EN
    , FLASH   = 3'd7
`endif
  } state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [4:0] timer;
  logic ped_pending, next_dir, ar_done;
  assign tick = cnt == TLAST;
  assign ar_done = tick && timer == ARD;
  always_comb begin
    nxt = st;
    case (st)
      NS_GREEN:  nxt = tick && (ew_car || ped_pending) && timer >= (ns_car ? GMX : GMN) ? NS_YELLOW : st;
      NS_YELLOW: nxt = tick && timer == YEL ? NS_ALLRED : st;
      NS_ALLRED: nxt = ar_done ? (ped_pending ? PED_WALK : EW_GREEN) : st;
      EW_GREEN:  nxt = tick && (ns_car || ped_pending) && timer >= (ew_car ? GMX : GMN) ? EW_YELLOW : st;
      EW_YELLOW: nxt = tick && timer == YEL ? EW_ALLRED : st;
      EW_ALLRED: nxt = ar_done ? (ped_pending ? PED_WALK : NS_GREEN) : st;
      PED_WALK:  nxt = tick && timer == WLK ? (next_dir ? NS_GREEN : EW_GREEN) : st;
`ifdef TRAFFIC_FLASH_EN
      FLASH:     nxt = tick && !flash ? NS_ALLRED : st;
`endif
      default:   nxt = NS_ALLRED;
    endcase
`ifdef TRAFFIC_FLASH_EN
    if (flash) nxt = FLASH;
`endif
  end
  // next_dir: 1 selects NS green after a walk, 0 selects EW
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      st          <= NS_GREEN;
      cnt         <= '0;
      timer       <= '0;
      ped_pending <= 1'b0;
      next_dir    <= 1'b0;
    end else begin
      st          <= nxt;
      cnt         <= tick ? '0 : cnt + 1'b1;
      timer       <= nxt != st ? 5'd0 : tick && timer != 5'd31 ? timer + 5'd1 : timer;
`ifdef TRAFFIC_FLASH_EN
      ped_pending <= !flash && (ped_req || (ped_pending && !(nxt == PED_WALK && st != PED_WALK)));
`else
      ped_pending <= ped_req || (ped_pending && !(nxt == PED_WALK && st != PED_WALK));
`endif
      next_dir    <= ar_done && st == NS_ALLRED ? 1'b0 : ar_done && st == EW_ALLRED ? 1'b1 : next_dir;
    end
`ifdef TRAFFIC_FLASH_EN
  logic blink;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) blink <= 1'b0;
    else blink <= st == FLASH ? blink ^ tick : 1'b0;
  assign lights = st == FLASH     ? {blink, 3'b000, blink, 1'b0} :
                  st == NS_GREEN  ? 6'b100_001 :
                  st == NS_YELLOW ? 6'b100_010 :
                  st == EW_GREEN  ? 6'b001_100 :
                  st == EW_YELLOW ? 6'b010_100 : 6'b100_100;
`else
  assign lights = st == NS_GREEN  ? 6'b100_001 :
                  st == NS_YELLOW ? 6'b100_010 :
                  st == EW_GREEN  ? 6'b001_100 :
                  st == EW_YELLOW ? 6'b010_100 : 6'b100_100;
`endif
  assign walk  = st == PED_WALK;
  assign phase = st;
endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer: randomized and directed checks of traffic_sequencer against a tick-counting phase model
module tb_traffic_sequencer;
  localparam int TD = 4, GMIN = 2, GMAX = 4, YT = 1, AT = 1, WT = 2;
  logic clk = 0, clr_n = 1, ns_car = 0, ew_car = 0, ped_req = 0;
`ifdef TRAFFIC_FLASH_EN
  logic flash = 0;
`endif
  logic [5:0] lights;
  logic walk, tick;
  logic [2:0] phase;
  int checks = 0, failures = 0;
  int m_ph, m_tin, m_c;
  bit m_pend, m_dir_ns;
  always #5 clk = ~clk;
  traffic_sequencer #(.TICK_DIV(TD), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
                      .YELLOW_T(YT), .ALLRED_T(AT), .WALK_T(WT)) dut (
    .clk(clk), .clr_n(clr_n), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
`ifdef TRAFFIC_FLASH_EN
    .flash(flash),
`endif
    .lights(lights), .walk(walk), .tick(tick), .phase(phase));
  function automatic logic [5:0] lamp(int ph);
    case (ph)
      0: return 6'b100_001;
      1: return 6'b100_010;
      3: return 6'b001_100;
      4: return 6'b010_100;
      default: return 6'b100_100;
    endcase
  endfunction
  function automatic logic [10:0] exp_bus();
    return {3'(m_ph), lamp(m_ph), m_ph == 6, (m_c % TD) == TD - 1};
  endfunction
  // drive one cycle of inputs, advance the model over the coming edge, land on the next negedge
  task automatic step(input logic ns, ew, ped);
    bit tk = (m_c % TD) == TD - 1;
    int nph = m_ph;
    ns_car = ns; ew_car = ew; ped_req = ped;
    if (tk)
      case (m_ph)
        0: if ((ew || m_pend) && m_tin + 1 >= (ns ? GMAX : GMIN)) nph = 1;
        1: if (m_tin + 1 == YT) nph = 2;
        2: if (m_tin + 1 == AT) begin nph = m_pend ? 6 : 3; m_dir_ns = 0; end
        3: if ((ns || m_pend) && m_tin + 1 >= (ew ? GMAX : GMIN)) nph = 4;
        4: if (m_tin + 1 == YT) nph = 5;
        5: if (m_tin + 1 == AT) begin nph = m_pend ? 6 : 0; m_dir_ns = 1; end
        6: if (m_tin + 1 == WT) nph = m_dir_ns ? 0 : 3;
        default: ;
      endcase
    m_pend = ped || (m_pend && !(nph == 6 && m_ph != 6));
    m_tin = nph != m_ph ? 0 : m_tin + int'(tk);
    m_ph = nph;
    m_c++;
    @(negedge clk);
  endtask
  task automatic do_reset(input logic ns, ew);
    clr_n = 0; ns_car = ns; ew_car = ew; ped_req = 0;
    repeat (2) @(negedge clk);
    m_ph = 0; m_tin = 0; m_c = 0; m_pend = 0; m_dir_ns = 0;
    clr_n = 1;
  endtask
  task automatic test_reset();
    #1 clr_n = 0;
    @(negedge clk);
    checks += 4;
    if (lights !== 6'b100_001) begin failures++; $display("FAIL reset_lights got=%b exp=100001", lights); end
    if (walk !== 1'b0) begin failures++; $display("FAIL reset_walk got=%b exp=0", walk); end
    if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
  endtask
  task automatic test_no_demand();
    int nt = 0;
    do_reset(0, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      nt += int'(tick);
      checks++;
      if ({phase, lights, walk, tick} !== exp_bus()) begin
        failures++;
        $display("FAIL no_demand cyc=%0d got=%b exp=%b", m_c, {phase, lights, walk, tick}, exp_bus());
      end
    end
    checks++;
    if (nt != 25) begin failures++; $display("FAIL tick_period ticks=%0d exp=25", nt); end
  endtask
  task automatic test_ew_demand();
    int ph[3] = '{0, 1, 2};
    int ln[3] = '{8, 4, 4};
    do_reset(0, 1);
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (phase == 3'(ph[k]) && n < 100) begin step(0, 1, 0); n++; end
      checks++;
      if (n != ln[k]) begin failures++; $display("FAIL ew_len ph=%0d got=%0d exp=%0d", ph[k], n, ln[k]); end
    end
    checks++;
    if (lights !== 6'b001_100 || phase !== 3'd3) begin
      failures++; $display("FAIL ew_green got lights=%b ph=%0d exp lights=001100 ph=3", lights, phase);
    end
  endtask
  task automatic test_both();
    int ph[6] = '{0, 1, 2, 3, 4, 5};
    int ln[6] = '{16, 4, 4, 16, 4, 4};
    do_reset(1, 1);
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      while (phase == 3'(ph[k]) && n < 100) begin step(1, 1, 0); n++; end
      checks++;
      if (n != ln[k]) begin failures++; $display("FAIL both_len ph=%0d got=%0d exp=%0d", ph[k], n, ln[k]); end
    end
    checks++;
    if (phase !== 3'd0) begin failures++; $display("FAIL both_return got=%0d exp=0", phase); end
  endtask
  task automatic test_ped();
    int ph[3] = '{1, 2, 6};
    int ln[3] = '{4, 4, 8};
    int nw = 0, n = 0;
    do_reset(0, 0);
    repeat (5) step(0, 0, 0);
    step(0, 0, 1);
    while (phase == 3'd0 && n < 100) begin step(0, 0, 0); n++; end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (phase == 3'(ph[k]) && n < 100) begin nw += int'(walk); step(0, 0, 0); n++; end
      checks++;
      if (n != ln[k]) begin failures++; $display("FAIL ped_len ph=%0d got=%0d exp=%0d", ph[k], n, ln[k]); end
    end
    checks += 3;
    if (nw != 8) begin failures++; $display("FAIL ped_walk_cycles got=%0d exp=8", nw); end
    if (phase !== 3'd3) begin failures++; $display("FAIL ped_after got=%0d exp=3", phase); end
    if (dut.ped_pending !== 1'b0) begin failures++; $display("FAIL ped_cleared got=%b exp=0", dut.ped_pending); end
  endtask
  task automatic test_ped_entry();
    int n = 0;
    do_reset(0, 0);
    step(0, 0, 1);
    while (phase != 3'd2 && n < 100) begin step(0, 0, 0); n++; end
    while (phase == 3'd2 && n < 200) begin step(0, 0, (m_c % TD) == TD - 1); n++; end
    checks++;
    if (phase !== 3'd6) begin failures++; $display("FAIL ped_entry_first got=%0d exp=6", phase); end
    n = 0;
    while (phase == 3'd6 && n < 100) begin step(0, 0, 0); n++; end
    n = 0;
    while (phase != 3'd6 && n < 100) begin
      step(0, 0, 0); n++;
      checks++;
      if ({phase, lights, walk, tick} !== exp_bus()) begin
        failures++;
        $display("FAIL ped_entry cyc=%0d got=%b exp=%b", m_c, {phase, lights, walk, tick}, exp_bus());
      end
    end
    checks++;
    if (phase !== 3'd6 || walk !== 1'b1) begin
      failures++; $display("FAIL ped_entry_second got ph=%0d walk=%b exp ph=6 walk=1", phase, walk);
    end
  endtask
  task automatic test_random();
    logic rns = 1'($urandom), rew = 1'($urandom);
    do_reset(rns, rew);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) rns = ~rns;
      if ($urandom_range(15) == 0) rew = ~rew;
      step(rns, rew, $urandom_range(24) == 0);
      checks++;
      if ({phase, lights, walk, tick} !== exp_bus()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", m_c, {phase, lights, walk, tick}, exp_bus());
      end
      checks++;
      if (lights[1:0] != 2'b00 && lights[4:3] != 2'b00) begin
        failures++; $display("FAIL conflict cyc=%0d got=%b exp=no_dual_go", m_c, lights);
      end
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    do_reset(0, 1);
    while (phase != 3'd3 && n < 100) begin step(0, 1, 0); n++; end
    while (phase != 3'd4 && n < 200) begin step(1, 0, 0); n++; end
    step(1, 0, 0);
    checks++;
    if (phase !== 3'd4) begin failures++; $display("FAIL mid_setup got=%0d exp=4", phase); end
    #2 clr_n = 0;
    #1;
    checks += 5;
    if (lights !== 6'b100_001) begin failures++; $display("FAIL mid_lights got=%b exp=100001", lights); end
    if (walk !== 1'b0) begin failures++; $display("FAIL mid_walk got=%b exp=0", walk); end
    if (phase !== 3'd0) begin failures++; $display("FAIL mid_phase got=%0d exp=0", phase); end
    if (dut.cnt !== '0) begin failures++; $display("FAIL mid_prescaler got=%0d exp=0", dut.cnt); end
    if (dut.timer !== 5'd0) begin failures++; $display("FAIL mid_timer got=%0d exp=0", dut.timer); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_no_demand();
    test_ew_demand();
    test_both();
    test_ped();
    test_ped_entry();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_sequencer.md
Name: traffic_sequencer

Overview:
- Demand-driven phase controller for one two-way intersection (NS/EW).
- Replaces the fixed-time cycle with one that responds to vehicle sensors and a latched pedestrian request.
- Generates its own second-tick from clk and runs a tick-based phase timer.
- Drives the 6-bit lamp bus and the pedestrian WALK lamp; sits between the sensor/button synchronisers and the lamp drivers.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick (>=2).
- GREEN_MIN, 10, minimum green in ticks (1..31).
- GREEN_MAX, 20, maximum green when opposing demand exists (GREEN_MIN..31).
- YELLOW_T, 3, yellow duration in ticks (1..31).
- ALLRED_T, 3, all-red clearance in ticks (1..31).
- WALK_T, 8, pedestrian scramble duration in ticks (1..31).

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- ns_car  input  1  NS vehicle present, level, pre-synchronised.
- ew_car  input  1  EW vehicle present, level, pre-synchronised.
- ped_req  input  1  pedestrian button; any high cycle sets the request latch.
- lights  output  6  [2:0] NS {red,yellow,green}, [5:3] EW {red,yellow,green}.
- walk  output  1  pedestrian WALK lamp.
- tick  output  1  one-cycle prescaler pulse.
- phase  output  3  current state code, for debug.

Behaviour:
- Reset is asynchronous on clr_n low. All registers clear together: state=NS_GREEN, prescaler=0, timer=0, ped_pending=0, next_dir=EW.
- Outputs while in reset: lights=6'b100_001, walk=0, tick=0, phase=0.
- Reset mid-phase abandons the phase immediately; nothing is retained.
- Prescaler: free-running 0..TICK_DIV-1. tick=1 for exactly the cycle in which the count equals TICK_DIV-1. It is never reset by state changes.
- Timer: 5-bit count of ticks spent in the current state. It is cleared in the cycle the state changes and incremented on tick otherwise. It saturates at 31.
- Transitions are evaluated only in tick cycles. Exit when "timer==T-1" means each timed state lasts exactly T*TICK_DIV cycles.
- State codes: NS_GREEN=0, NS_YELLOW=1, NS_ALLRED=2, EW_GREEN=3, EW_YELLOW=4, EW_ALLRED=5, PED_WALK=6. Code 7 is illegal.
- Demand for NS_GREEN is ew_car|ped_pending; demand for EW_GREEN is ns_car|ped_pending. "Own car" is ns_car in NS_GREEN and ew_car in EW_GREEN.
- NS_GREEN/EW_GREEN:
  - No demand: rest in green indefinitely.
  - Demand, own car absent: exit at timer>=GREEN_MIN-1.
  - Demand, own car present: exit at timer>=GREEN_MAX-1.
  - Exit goes to the matching YELLOW.
- NS_YELLOW/EW_YELLOW: exit at timer==YELLOW_T-1 to the matching ALLRED.
- NS_ALLRED/EW_ALLRED: exit at timer==ALLRED_T-1.
  - If ped_pending, go to PED_WALK; otherwise go to the opposite green.
  - On this exit, next_dir is set to the opposite direction.
- PED_WALK: exit at timer==WALK_T-1 to the green selected by next_dir.
- ped_pending: set by ped_req, cleared in the cycle PED_WALK is entered. If set and clear coincide, set wins, so a press in the entry cycle is kept pending.
- Illegal state code 7: recover to NS_ALLRED with timer=0 on the next clock edge, without waiting for a tick.
- Lamp decode (combinational from state, zero latency):
  - NS_GREEN 100_001
  - NS_YELLOW 100_010
  - NS_ALLRED 100_100
  - EW_GREEN 001_100
  - EW_YELLOW 010_100
  - EW_ALLRED 100_100
  - PED_WALK 100_100 with walk=1
  - walk=0 in every other state.
- Invariant: no green or yellow on both roads in any cycle.

Optional Feature:
- Macro TRAFFIC_FLASH_EN.
- When defined:
  - Adds input port flash (1 bit) and state FLASH=7. State code 7 is then legal only under this macro.
  - flash high forces FLASH on the next clock edge from any state and clears ped_pending.
  - In FLASH: NS yellow and EW red blink, toggling on every tick. walk=0.
  - flash low exits on the next tick to NS_ALLRED with timer=0.
- When undefined: no flash port, and code 7 is treated as illegal.

Test Plan:
- TICK_DIV=4, GREEN_MIN=2, GREEN_MAX=4, YELLOW_T=1, ALLRED_T=1; release reset with no demand for 100 cycles -> lights stays 100_001, phase 0, tick period 4 cycles.
- Hold ew_car=1, ns_car=0 -> NS_GREEN lasts 8 cycles, NS_YELLOW 4, NS_ALLRED 4, then EW_GREEN lights=001_100.
- Hold ns_car=1 and ew_car=1 -> each green lasts 16 cycles (GREEN_MAX); NS and EW alternate.
- Pulse ped_req for 1 cycle during NS_GREEN with WALK_T=2 -> NS yellow, all-red, then PED_WALK walk=1 for 8 cycles, then EW_GREEN; ped_pending=0.
- Assert ped_req in the PED_WALK entry cycle -> after the next green/yellow/all-red a second PED_WALK occurs.
- Drop clr_n mid EW_YELLOW -> lights=100_001 and walk=0 in the same cycle; prescaler and timer read 0.
